// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: fetch-state
// encoding, reset code address and decode window geometry.
package prefetch_queue_pkg;

  // Fetch engine states. DROP waits out a response orphaned by a flush.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } prefetch_state_t;

  // 80386 reset EIP: execution starts 16 bytes below the top of memory.
  localparam logic [31:0] reset_code_address = 32'hFFFF_FFF0;

  // Bytes presented to the decoder at once (longest x86 instruction + 1).
  localparam int decode_window_bytes = 16;

  // Size of one bus code fetch in bytes.
  localparam int fetch_word_bytes = 4;

  // A retire length is only meaningful for 1..15 bytes.
  function automatic logic consume_length_ok(input logic [4:0] len);
    return (len != 5'd0) && (len <= 5'd15);
  endfunction

endpackage

// File: rtl/prefetch_queue_window.sv
// Decode window: rotates the circular byte queue so that the byte at the
// read pointer appears at position 0, and zeroes positions past the
// number of queued bytes.
module prefetch_queue_window
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic [7:0]       i_queue [DEPTH],
  input  logic [PTR_W-1:0] i_rd_ptr,
  input  logic [CNT_W-1:0] i_count,
  output logic [7:0]       o_instruction [0:decode_window_bytes-1],
  output logic [4:0]       o_window_count
);

  // Rotate and mask; the pointer sum wraps naturally at DEPTH.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path, otherwise synthesis infers a latch to hold the old value.
    o_window_count = 5'd0;
    for (int i = 0; i < decode_window_bytes; i++) begin
      o_instruction[i] = 8'h00;
      if (CNT_W'(i) < i_count) begin
        o_instruction[i] = i_queue[i_rd_ptr + PTR_W'(i)];
      end
    end
    if (i_count >= CNT_W'(decode_window_bytes)) begin
      o_window_count = 5'(decode_window_bytes);
    end else begin
      o_window_count = i_count[4:0];
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches aligned code words from the bus unit
// into a circular byte queue and presents a 16-byte window at the current
// instruction pointer to the decoder, which retires bytes by length.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_address,
  output logic        fetch_req,
  output logic [31:0] fetch_address,
  input  logic        fetch_ready,
  input  logic        fetch_data_valid,
  input  logic [31:0] fetch_data,
  output logic [7:0]  instruction [0:15],
  output logic [4:0]  window_count,
  output logic [31:0] window_address,
  input  logic        consume_valid,
  input  logic [4:0]  consume_length,
  output logic        consume_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] FREE_NEEDED = (CNT_W + 1)'(fetch_word_bytes);

  // Storage and bookkeeping.
  logic [7:0]       r_queue [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_skip;
  logic [31:0]      r_window_address;
  logic [31:0]      r_fetch_address;
  logic             r_consume_error;
  prefetch_state_t  r_state;

  // Combinational control.
  prefetch_state_t  w_state_next;
  logic             w_handshake;
  logic             w_response;
  logic             w_write;
  logic             w_consume_legal;
  logic             w_consume;
  logic [2:0]       w_written;
  logic [CNT_W:0]   w_reserved;
  logic [CNT_W:0]   w_free;
  logic [CNT_W-1:0] w_count_add;
  logic [CNT_W-1:0] w_count_sub;

  assign w_handshake = (r_state == REQ) && fetch_ready;
  assign w_response  = (r_state == WAIT) && fetch_data_valid;
  // A flush discards a response landing in the same cycle.
  assign w_write     = w_response && !flush;

  assign w_consume_legal = consume_valid && consume_length_ok(consume_length) &&
                           (CNT_W'(consume_length) <= r_count);
  assign w_consume       = w_consume_legal && !flush;

  // An unaligned restart only keeps the bytes at and above the target.
  assign w_written   = 3'(fetch_word_bytes) - {1'b0, r_skip};

  // One outstanding word holds back four bytes of space until it lands.
  assign w_reserved  = ((r_state == WAIT) || (r_state == DROP)) ? FREE_NEEDED : '0;
  assign w_free      = (CNT_W + 1)'(DEPTH) - {1'b0, r_count} - w_reserved;

  assign w_count_add = w_write   ? CNT_W'(w_written)      : '0;
  assign w_count_sub = w_consume ? CNT_W'(consume_length) : '0;

  // Fetch state transitions; flush redirects to DROP whenever a response
  // is still owed by the bus so that stale code never enters the queue.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!flush && (w_free >= FREE_NEEDED)) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          w_state_next = w_handshake ? DROP : IDLE;
        end else if (w_handshake) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        // A response coinciding with a flush is the owed one; it is
        // dropped here, so no further response needs waiting out.
        if (fetch_data_valid) begin
          w_state_next = IDLE;
        end else if (flush) begin
          w_state_next = DROP;
        end
      end
      DROP: begin
        if (fetch_data_valid) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of block order.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointers, occupancy, skip and the two linear addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_skip           <= 2'd0;
      r_window_address <= reset_code_address;
      r_fetch_address  <= reset_code_address;
    end else if (flush) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_skip           <= flush_address[1:0];
      r_window_address <= flush_address;
      r_fetch_address  <= {flush_address[31:2], 2'b00};
    end else begin
      if (w_handshake) begin
        r_fetch_address <= r_fetch_address + 32'(fetch_word_bytes);
      end
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_written);
        r_skip   <= 2'd0;
      end
      if (w_consume) begin
        r_rd_ptr         <= r_rd_ptr + PTR_W'(consume_length);
        r_window_address <= r_window_address + 32'(consume_length);
      end
      r_count <= r_count + w_count_add - w_count_sub;
    end
  end

  // Byte storage: drop the leading skip bytes, pack the rest at wr_ptr.
  always_ff @(posedge clk) begin
    // NOTE: the byte array has no reset; contents beyond count are never
    // observed because the window masks them, so reset would only cost area.
    if (w_write) begin
      for (int j = 0; j < fetch_word_bytes; j++) begin
        if (j >= int'(r_skip)) begin
          r_queue[r_wr_ptr + PTR_W'(j) - PTR_W'(r_skip)] <= fetch_data[8*j +: 8];
        end
      end
    end
  end

  // One-cycle pulse for any consume that cannot be honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_consume_error <= 1'b0;
    end else begin
      r_consume_error <= consume_valid && !w_consume_legal;
    end
  end

  prefetch_queue_window #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_window (
    .i_queue        (r_queue),
    .i_rd_ptr       (r_rd_ptr),
    .i_count        (r_count),
    .o_instruction  (instruction),
    .o_window_count (window_count)
  );

  assign fetch_req      = (r_state == REQ);
  assign fetch_address  = r_fetch_address;
  assign window_address = r_window_address;
  assign consume_error  = r_consume_error;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: reset fetch, unaligned flush,
// full-queue throttling, flush during an outstanding fetch, illegal
// consumes, combined write+consume, and reset during a request stall.
module tb_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_address;
  logic        fetch_req;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic        fetch_data_valid;
  logic [31:0] fetch_data;
  logic [7:0]  instruction [0:15];
  logic [4:0]  window_count;
  logic [31:0] window_address;
  logic        consume_valid;
  logic [4:0]  consume_length;
  logic        consume_error;

  int total;
  int bad;

  prefetch_queue #(.DEPTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .flush_address    (flush_address),
    .fetch_req        (fetch_req),
    .fetch_address    (fetch_address),
    .fetch_ready      (fetch_ready),
    .fetch_data_valid (fetch_data_valid),
    .fetch_data       (fetch_data),
    .instruction      (instruction),
    .window_count     (window_count),
    .window_address   (window_address),
    .consume_valid    (consume_valid),
    .consume_length   (consume_length),
    .consume_error    (consume_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a fetch request.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!fetch_req && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (fetch_req !== 1'b1) begin
      bad++;
      $display("FAIL %s fetch_req timeout got=%b want=1", name, fetch_req);
    end
  endtask

  // Zero-wait bus: accept the request, return the word the next cycle.
  task automatic serve_word(input string name, input logic [31:0] addr, input logic [31:0] data);
    wait_req(name);
    total++;
    if (fetch_address !== addr) begin
      bad++;
      $display("FAIL %s fetch_address got=%h want=%h", name, fetch_address, addr);
    end
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    fetch_data_valid = 1'b1;
    fetch_data = data;
    cycle();
    fetch_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    total++;
    if (fetch_req !== 1'b0) begin
      bad++; $display("FAIL reset_req got=%b want=0", fetch_req);
    end
    total++;
    if (fetch_address !== 32'hFFFF_FFF0) begin
      bad++; $display("FAIL reset_faddr got=%h want=fffffff0", fetch_address);
    end
    total++;
    if (window_address !== 32'hFFFF_FFF0 || window_count !== 5'd0 || consume_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_window got addr=%h cnt=%0d err=%b want addr=fffffff0 cnt=0 err=0",
               window_address, window_count, consume_error);
    end
    rst_n = 1'b1;
    cycle();
    total++;
    if (fetch_req !== 1'b1) begin
      bad++; $display("FAIL reset_first_req got=%b want=1", fetch_req);
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      serve_word("zero_wait", 32'hFFFF_FFF0 + 32'(4 * i), 32'h1312_1110 + 32'(i) * 32'h0404_0404);
    end
    total++;
    if (window_count !== 5'd16) begin
      bad++; $display("FAIL zw_count got=%0d want=16", window_count);
    end
    total++;
    if (instruction[0] !== 8'h10 || instruction[15] !== 8'h1F) begin
      bad++; $display("FAIL zw_bytes got=%h/%h want=10/1f", instruction[0], instruction[15]);
    end
  endtask

  task automatic test_flush_unaligned();
    flush = 1'b1;
    flush_address = 32'h0000_1003;
    cycle();
    flush = 1'b0;
    total++;
    if (window_count !== 5'd0 || window_address !== 32'h0000_1003) begin
      bad++; $display("FAIL fl_window got cnt=%0d addr=%h want cnt=0 addr=00001003", window_count, window_address);
    end
    serve_word("fl_fetch", 32'h0000_1000, 32'h4433_2211);
    total++;
    if (window_count !== 5'd1 || instruction[0] !== 8'h44 || instruction[1] !== 8'h00) begin
      bad++;
      $display("FAIL fl_bytes got cnt=%0d b0=%h b1=%h want cnt=1 b0=44 b1=00",
               window_count, instruction[0], instruction[1]);
    end
    total++;
    if (window_address !== 32'h0000_1003) begin
      bad++; $display("FAIL fl_waddr got=%h want=00001003", window_address);
    end
    wait_req("fl_next");
    total++;
    if (fetch_address !== 32'h0000_1004) begin
      bad++; $display("FAIL fl_next_addr got=%h want=00001004", fetch_address);
    end
  endtask

  task automatic test_full();
    logic saw_req;
    int n;
    flush = 1'b1;
    flush_address = 32'h0000_2000;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve_word("full_fill", 32'h0000_2000 + 32'(4 * i), 32'h0302_0100 + 32'(i) * 32'h0404_0404);
    end
    saw_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_req) saw_req = 1'b1;
      cycle();
    end
    total++;
    if (saw_req !== 1'b0) begin
      bad++; $display("FAIL full_noreq got=%b want=0", saw_req);
    end
    total++;
    if (window_count !== 5'd16 || instruction[1] !== 8'h01 || instruction[15] !== 8'h0F) begin
      bad++;
      $display("FAIL full_window got cnt=%0d b1=%h b15=%h want 16/01/0f", window_count, instruction[1], instruction[15]);
    end
    consume_valid = 1'b1;
    consume_length = 5'd4;
    cycle();
    consume_valid = 1'b0;
    total++;
    if (window_address !== 32'h0000_2004 || instruction[0] !== 8'h04 || consume_error !== 1'b0) begin
      bad++;
      $display("FAIL full_consume got addr=%h b0=%h err=%b want 00002004/04/0",
               window_address, instruction[0], consume_error);
    end
    n = 0;
    while (!fetch_req && n < 2) begin
      cycle();
      n++;
    end
    total++;
    if (fetch_req !== 1'b1 || fetch_address !== 32'h0000_2020) begin
      bad++; $display("FAIL full_resume got req=%b addr=%h want 1/00002020", fetch_req, fetch_address);
    end
  endtask

  task automatic test_flush_wait();
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    flush = 1'b1;
    flush_address = 32'h0000_3000;
    cycle();
    flush = 1'b0;
    total++;
    if (window_count !== 5'd0 || window_address !== 32'h0000_3000) begin
      bad++; $display("FAIL fw_window got cnt=%0d addr=%h want 0/00003000", window_count, window_address);
    end
    cycle();
    total++;
    if (fetch_req !== 1'b0) begin
      bad++; $display("FAIL fw_drop_req got=%b want=0", fetch_req);
    end
    fetch_data_valid = 1'b1;
    fetch_data = 32'hAABB_CCDD;
    cycle();
    fetch_data_valid = 1'b0;
    total++;
    if (window_count !== 5'd0) begin
      bad++; $display("FAIL fw_dropped got cnt=%0d want=0", window_count);
    end
    wait_req("fw_refetch");
    total++;
    if (fetch_address !== 32'h0000_3000) begin
      bad++; $display("FAIL fw_refetch_addr got=%h want=00003000", fetch_address);
    end
  endtask

  task automatic test_consume_error();
    flush = 1'b1;
    flush_address = 32'h0000_4002;
    cycle();
    flush = 1'b0;
    serve_word("ce_w0", 32'h0000_4000, 32'h4433_2211);
    serve_word("ce_w1", 32'h0000_4004, 32'h8877_6655);
    total++;
    if (window_count !== 5'd6 || instruction[0] !== 8'h33 || instruction[5] !== 8'h88) begin
      bad++;
      $display("FAIL ce_fill got cnt=%0d b0=%h b5=%h want 6/33/88", window_count, instruction[0], instruction[5]);
    end
    consume_valid = 1'b1;
    consume_length = 5'd7;
    cycle();
    consume_valid = 1'b0;
    total++;
    if (consume_error !== 1'b1) begin
      bad++; $display("FAIL ce_pulse got=%b want=1", consume_error);
    end
    total++;
    if (window_count !== 5'd6 || window_address !== 32'h0000_4002 || instruction[0] !== 8'h33) begin
      bad++;
      $display("FAIL ce_unchanged got cnt=%0d addr=%h b0=%h want 6/00004002/33",
               window_count, window_address, instruction[0]);
    end
    cycle();
    total++;
    if (consume_error !== 1'b0) begin
      bad++; $display("FAIL ce_one_cycle got=%b want=0", consume_error);
    end
    consume_valid = 1'b1;
    consume_length = 5'd0;
    cycle();
    consume_valid = 1'b0;
    total++;
    if (consume_error !== 1'b1 || window_count !== 5'd6) begin
      bad++; $display("FAIL ce_zero_len got err=%b cnt=%0d want 1/6", consume_error, window_count);
    end
  endtask

  task automatic test_back_to_back();
    wait_req("bb_req");
    total++;
    if (fetch_address !== 32'h0000_4008) begin
      bad++; $display("FAIL bb_addr got=%h want=00004008", fetch_address);
    end
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    fetch_data_valid = 1'b1;
    fetch_data = 32'hCCBB_AA99;
    consume_valid = 1'b1;
    consume_length = 5'd3;
    cycle();
    fetch_data_valid = 1'b0;
    consume_valid = 1'b0;
    total++;
    if (window_count !== 5'd7 || window_address !== 32'h0000_4005) begin
      bad++; $display("FAIL bb_count got cnt=%0d addr=%h want 7/00004005", window_count, window_address);
    end
    total++;
    if (instruction[0] !== 8'h66 || instruction[6] !== 8'hCC || instruction[7] !== 8'h00) begin
      bad++;
      $display("FAIL bb_bytes got %h/%h/%h want 66/cc/00", instruction[0], instruction[6], instruction[7]);
    end
  endtask

  task automatic test_reset_stall();
    wait_req("rs_req");
    cycle();
    cycle();
    total++;
    if (fetch_req !== 1'b1 || fetch_address !== 32'h0000_400C) begin
      bad++; $display("FAIL rs_stall got req=%b addr=%h want 1/0000400c", fetch_req, fetch_address);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (fetch_req !== 1'b0 || fetch_address !== 32'hFFFF_FFF0) begin
      bad++; $display("FAIL rs_async got req=%b addr=%h want 0/fffffff0", fetch_req, fetch_address);
    end
    total++;
    if (window_count !== 5'd0 || window_address !== 32'hFFFF_FFF0) begin
      bad++; $display("FAIL rs_window got cnt=%0d addr=%h want 0/fffffff0", window_count, window_address);
    end
    cycle();
    rst_n = 1'b1;
    fetch_data_valid = 1'b1;
    fetch_data = 32'h5A5A_5A5A;
    cycle();
    fetch_data_valid = 1'b0;
    total++;
    if (window_count !== 5'd0 || fetch_req !== 1'b1 || fetch_address !== 32'hFFFF_FFF0) begin
      bad++;
      $display("FAIL rs_restart got cnt=%0d req=%b addr=%h want 0/1/fffffff0",
               window_count, fetch_req, fetch_address);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    flush_address = 32'h0;
    fetch_ready = 1'b0;
    fetch_data_valid = 1'b0;
    fetch_data = 32'h0;
    consume_valid = 1'b0;
    consume_length = 5'd0;
    test_reset();
    test_zero_wait();
    test_flush_unaligned();
    test_full();
    test_flush_wait();
    test_consume_error();
    test_back_to_back();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
